// File: rtl/ofmap_collector.sv
// Output-feature-map collector: gathers systolic-array result beats into a local
// buffer, then drains the buffer element by element over a valid/ready stream.
module ofmap_collector #(
  parameter int unsigned dataSize    = 8,
  parameter int unsigned numRegister = 256,
  parameter int unsigned nElementsIn = 4
) (
  input  logic                                 clk,
  input  logic                                 nrst,
  input  logic [nElementsIn-1:0][dataSize-1:0] in_data,
  input  logic                                 in_valid,
  input  logic [15:0]                          cfg_ofmap_width,
  input  logic                                 ctrl_start,
  output logic [dataSize-1:0]                  out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 flag_done,
  output logic                                 flag_overflow
);

  localparam int unsigned nAddress = (numRegister > 1) ? $clog2(numRegister) : 1;
  // 48 bits holds width^2 * nElementsIn for any 16-bit width without wrapping
  localparam int unsigned CNT_W    = 48;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [CNT_W-1:0]    r_pix_cnt;
  logic [CNT_W-1:0]    r_drain_cnt;
  logic [CNT_W-1:0]    r_total_px;
  logic [dataSize-1:0] r_buf [numRegister];
  logic [dataSize-1:0] r_out_data;
  logic                r_out_valid;
  logic                r_done;
  logic                r_ovf;

  logic [CNT_W-1:0]       w_addr [nElementsIn];
  logic [nElementsIn-1:0] w_in_range;
  logic [CNT_W-1:0]       w_total_el;
  logic [CNT_W-1:0]       w_drain_total;
  logic                   w_start;
  logic                   w_collect;
  logic                   w_load;
  logic                   w_finish;

  assign out_data      = r_out_data;
  assign out_valid     = r_out_valid;
  assign flag_done     = r_done;
  assign flag_overflow = r_ovf;

  // Per-element buffer address of the current beat and its range check
  always_comb begin
    for (int unsigned k = 0; k < nElementsIn; k++) begin
      w_addr[k]     = r_pix_cnt * CNT_W'(nElementsIn) + CNT_W'(k);
      w_in_range[k] = (w_addr[k] < CNT_W'(numRegister));
    end
  end

  assign w_total_el    = r_total_px * CNT_W'(nElementsIn);
  assign w_drain_total = (w_total_el < CNT_W'(numRegister)) ? w_total_el
                                                             : CNT_W'(numRegister);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_collect   = 1'b0;
    w_load      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ctrl_start) begin
          w_start     = 1'b1;
          w_state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (r_pix_cnt >= r_total_px) begin
          w_state_nxt = S_DRAIN;
        end else if (in_valid) begin
          w_collect = 1'b1;
          if ((r_pix_cnt + CNT_W'(1)) >= r_total_px) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Advance when the output register is empty or being consumed this edge
        if (!r_out_valid || out_ready) begin
          if (r_drain_cnt < w_drain_total) begin
            w_load = 1'b1;
          end else begin
            w_finish    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned a = 0; a < numRegister; a++) begin
        r_buf[a] <= '0;
      end
    end else if (w_collect) begin
      for (int unsigned k = 0; k < nElementsIn; k++) begin
        if (w_in_range[k]) begin
          r_buf[w_addr[k][nAddress-1:0]] <= in_data[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pix_cnt   <= '0;
      r_drain_cnt <= '0;
      r_total_px  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_start) begin
        r_pix_cnt   <= '0;
        r_drain_cnt <= '0;
        r_ovf       <= 1'b0;
        r_total_px  <= CNT_W'(cfg_ofmap_width) * CNT_W'(cfg_ofmap_width);
      end
      if (w_collect) begin
        r_pix_cnt <= r_pix_cnt + CNT_W'(1);
        if (!(&w_in_range)) begin
          r_ovf <= 1'b1;
        end
      end
      if (w_load) begin
        r_out_data  <= r_buf[r_drain_cnt[nAddress-1:0]];
        r_out_valid <= 1'b1;
        r_drain_cnt <= r_drain_cnt + CNT_W'(1);
      end else if (w_finish) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ofmap_collector.sv
// Scoreboard bench for ofmap_collector: a reference buffer model queues the
// expected drain stream, a negedge monitor pops and compares each transfer.
module tb_ofmap_collector;

  localparam int unsigned DW   = 8;
  localparam int unsigned NREG = 16;
  localparam int unsigned NEL  = 4;

  logic                    clk = 1'b0;
  logic                    nrst;
  logic [NEL-1:0][DW-1:0]  in_data;
  logic                    in_valid;
  logic [15:0]             cfg_ofmap_width;
  logic                    ctrl_start;
  logic [DW-1:0]           out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    flag_done;
  logic                    flag_overflow;

  ofmap_collector #(
    .dataSize    (DW),
    .numRegister (NREG),
    .nElementsIn (NEL)
  ) dut (
    .clk             (clk),
    .nrst            (nrst),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .cfg_ofmap_width (cfg_ofmap_width),
    .ctrl_start      (ctrl_start),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .flag_done       (flag_done),
    .flag_overflow   (flag_overflow)
  );

  always #5 clk = ~clk;

  int           n_vec = 0;
  int           n_err = 0;
  int           n_xfer = 0;
  int           n_done = 0;
  int           n_valid = 0;
  logic [DW-1:0] mdl [NREG];
  logic [DW-1:0] exp_q [$];
  logic          exp_ovf;
  logic          rdy_tog = 1'b0;
  logic          rdy_hold = 1'b0;
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_val = '0;
  logic          prev_more = 1'b0;
  logic          prev_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Downstream ready pattern, updated just after each rising edge
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_hold ? 1'b0 : (rdy_tog ? ~out_ready : 1'b1);
    end
  end

  always @(negedge clk) begin
    if (!nrst) begin
      hold_pend = 1'b0;
      prev_more = 1'b0;
      prev_last = 1'b0;
    end else begin
      if (hold_pend) begin
        check("stall_hold_data", 32'(out_data), 32'(hold_val));
        check("stall_hold_valid", 32'(out_valid), 32'd1);
      end
      if (prev_more) check("no_bubble", 32'(out_valid), 32'd1);
      if (prev_last) begin
        check("done_after_last", 32'(flag_done), 32'd1);
        check("valid_drop_after_last", 32'(out_valid), 32'd0);
      end
      hold_pend = out_valid && !out_ready;
      hold_val  = out_data;
      prev_more = 1'b0;
      prev_last = 1'b0;
      if (out_valid) n_valid++;
      if (flag_done) n_done++;
      if (out_valid && out_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          check("spurious_beat", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          check("drain_data", 32'(out_data), 32'(exp_q.pop_front()));
          prev_more = (exp_q.size() != 0);
          prev_last = !prev_more;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input int w);
    cfg_ofmap_width = 16'(w);
    ctrl_start      = 1'b1;
    @(posedge clk);
    #1;
    ctrl_start = 1'b0;
  endtask

  task automatic send_beat(input int p, input int seed);
    int addr;
    for (int k = 0; k < int'(NEL); k++) begin
      in_data[k] = DW'(seed + p * int'(NEL) + k);
      addr = p * int'(NEL) + k;
      if (addr < int'(NREG)) mdl[addr] = DW'(seed + p * int'(NEL) + k);
      else exp_ovf = 1'b1;
    end
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int c;
    c = 0;
    while (n_done == d0 && c < 400) begin
      @(posedge clk);
      c++;
    end
    #1;
    check("done_seen", (n_done != d0) ? 32'd1 : 32'd0, 32'd1);
    check("done_pulse_width", 32'(flag_done), 32'd0);
    check("idle_valid_low", 32'(out_valid), 32'd0);
  endtask

  task automatic run_pass(input int w, input int seed, input logic tog, input logic disturb);
    int total, ndrain, x0, d0, v0;
    total  = w * w * int'(NEL);
    ndrain = (total < int'(NREG)) ? total : int'(NREG);
    rdy_tog = tog;
    exp_ovf = 1'b0;
    do_start(w);
    check("ovf_clear_on_start", 32'(flag_overflow), 32'd0);
    for (int p = 0; p < w * w; p++) begin
      if (p % 2 == 1) begin
        @(posedge clk);
        #1;
      end
      send_beat(p, seed);
      if (p == 0) cfg_ofmap_width = 16'(w + 3);
      check("ovf_after_beat", 32'(flag_overflow), 32'(exp_ovf));
    end
    for (int a = 0; a < ndrain; a++) exp_q.push_back(mdl[a]);
    x0 = n_xfer;
    d0 = n_done;
    v0 = n_valid;
    if (disturb) begin
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      for (int k = 0; k < int'(NEL); k++) in_data[k] = DW'(8'hEE);
      ctrl_start = 1'b1;
      in_valid   = 1'b1;
      @(posedge clk);
      #1;
      ctrl_start = 1'b0;
      in_valid   = 1'b0;
    end
    wait_done(d0);
    check("xfer_count", 32'(n_xfer - x0), 32'(ndrain));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("ovf_final", 32'(flag_overflow), 32'(exp_ovf));
    if (ndrain == 0) check("no_valid_cycles", 32'(n_valid - v0), 32'd0);
    rdy_tog = 1'b0;
  endtask

  task automatic idle_poke();
    int v0, d0;
    v0 = n_valid;
    d0 = n_done;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < int'(NEL); k++) in_data[k] = DW'(8'hA0 + k);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("idle_ovf_unchanged", 32'(flag_overflow), 32'd0);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_no_valid", 32'(n_valid - v0), 32'd0);
    check("idle_no_done", 32'(n_done - d0), 32'd0);
  endtask

  initial begin
    nrst            = 1'b0;
    in_valid        = 1'b0;
    in_data         = '0;
    ctrl_start      = 1'b0;
    cfg_ofmap_width = '0;
    exp_ovf         = 1'b0;
    for (int a = 0; a < int'(NREG); a++) mdl[a] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_flag_done", 32'(flag_done), 32'd0);
    check("rst_flag_overflow", 32'(flag_overflow), 32'd0);
    nrst = 1'b1;

    // width 2, ramp 0..15, ready always high
    run_pass(2, 0, 1'b0, 1'b0);
    // ready toggling, start/in_valid poked during drain
    run_pass(2, 8'h30, 1'b1, 1'b1);
    idle_poke();
    // width 3 overflows the 16-entry buffer from the fifth beat on
    run_pass(3, 8'h50, 1'b0, 1'b0);
    run_pass(0, 0, 1'b1, 1'b0);

    // reset asserted while a drained element is stalled on the output
    rdy_hold = 1'b1;
    exp_ovf  = 1'b0;
    do_start(2);
    send_beat(0, 8'h20);
    send_beat(1, 8'h20);
    send_beat(2, 8'h20);
    send_beat(3, 8'h20);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_data", 32'(out_data), 32'h20);
    nrst = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_data", 32'(out_data), 32'd0);
    check("async_rst_done", 32'(flag_done), 32'd0);
    check("async_rst_ovf", 32'(flag_overflow), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < int'(NREG); a++) mdl[a] = '0;
    exp_q.delete();
    rdy_hold = 1'b0;
    nrst     = 1'b1;
    run_pass(2, 8'h70, 1'b1, 1'b0);
    run_pass(1, 8'h90, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ofmap_collector.md
OFMAP_COLLECTOR -- requirements
Module: ofmap_collector

Interface
REQ-001 SHALL have parameter dataSize, default 8: width of one output element in bits.
REQ-002 SHALL have parameter numRegister, default 256: output buffer depth in elements; nAddress = clog2(numRegister).
REQ-003 SHALL have parameter nElementsIn, default 4: elements per systolic-array result beat, one per output channel.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port nrst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port in_data, input, nElementsIn x dataSize: one result beat for one ofmap pixel.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data holds a beat this cycle.
REQ-008 SHALL have port cfg_ofmap_width, input, 16 bits: ofmap side length; pixel count is cfg_ofmap_width squared.
REQ-009 SHALL have port ctrl_start, input, 1 bit: starts a collect pass.
REQ-010 SHALL have port out_data, output, dataSize: drained element.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-013 SHALL have port flag_done, output, 1 bit: one-cycle pulse when the drain completes.
REQ-014 SHALL have port flag_overflow, output, 1 bit: sticky; an element addressed at or beyond numRegister was dropped.

Function
REQ-015 SHALL hold registered state S_IDLE, S_COLLECT, S_DRAIN; reset state S_IDLE.
REQ-016 SHALL go S_IDLE to S_COLLECT on ctrl_start; ctrl_start outside S_IDLE is ignored.
REQ-017 SHALL clear pixel counter, drain counter and flag_overflow on S_IDLE to S_COLLECT.
REQ-018 SHALL, in S_COLLECT on in_valid, write in_data[k] to buffer address pixel_cnt*nElementsIn+k for k = 0..nElementsIn-1 in that cycle, and increment pixel_cnt.
REQ-019 SHALL ignore in_valid outside S_COLLECT; no buffer write, no counter change.
REQ-020 SHALL, for any element whose address is at or beyond numRegister, drop only that element and set flag_overflow; in-range elements of the same beat are still written.
REQ-021 SHALL compute addresses and totals at least 32 bits wide so no product wraps before the range check.
REQ-022 SHALL go S_COLLECT to S_DRAIN in the cycle after the beat that makes pixel_cnt reach cfg_ofmap_width squared.
REQ-023 SHALL, if cfg_ofmap_width is 0, go S_COLLECT to S_DRAIN and then S_DRAIN to S_IDLE with no out_valid beats, still pulsing flag_done.
REQ-024 SHALL, in S_DRAIN, present elements at addresses 0 to min(total, numRegister)-1 in ascending order, where total = cfg_ofmap_width squared times nElementsIn.
REQ-025 SHALL register out_data and out_valid; the first out_valid is asserted the cycle after entering S_DRAIN.
REQ-026 SHALL treat out_valid and out_ready high together on a rising edge as a transfer; the next element is then presented on the following cycle with no bubble.
REQ-027 SHALL hold out_data stable while out_valid is high and out_ready is low.
REQ-028 SHALL, on the last transfer, deassert out_valid next cycle, pulse flag_done for exactly that one cycle, and return to S_IDLE.
REQ-029 SHALL keep buffer contents across passes; it is not cleared on start.
REQ-030 SHALL sample cfg_ofmap_width only at the S_IDLE to S_COLLECT transition; changes mid-pass have no effect.

Reset
REQ-031 SHALL, on nrst low at any time including mid-collect or mid-drain, immediately force S_IDLE, counters 0, out_valid 0, out_data 0, flag_done 0 and flag_overflow 0.
REQ-032 SHALL reset all buffer registers to 0.
REQ-033 SHALL accept ctrl_start on the first rising edge after nrst deasserts.

Verification
REQ-034 SHALL pass this test: width 2, nElementsIn 4, 4 beats of {p*4+k}, out_ready high -> out_data 0..15 on 16 consecutive cycles, then flag_done for 1 cycle.
REQ-035 SHALL pass this test: as REQ-034 with out_ready toggling 1,0 -> each value is held while stalled, no loss or duplication, 16 transfers.
REQ-036 SHALL pass this test: numRegister 16, width 3, nElementsIn 4 -> flag_overflow set at beat 5, exactly 16 elements drained, flag_done pulses.
REQ-037 SHALL pass this test: nrst pulsed after 2 of 4 beats -> all outputs 0 and S_IDLE; a fresh pass then drains correct data.
REQ-038 SHALL pass this test: in_valid and ctrl_start driven in S_IDLE and S_DRAIN -> no buffer change and no state change.
REQ-039 SHALL pass this test: cfg_ofmap_width 0 -> no out_valid, flag_done pulses, return to S_IDLE.
